cpu_oci_trace_packer: RTL and testbench

CPU_OCI_TRACE_PACKER -- requirements
Module: cpu_oci_trace_packer

---
 rtl/cpu_oci_trace_pkg.sv | 25 ++
 rtl/cpu_oci_trace_fifo.sv | 74 +++++++
 rtl/cpu_oci_trace_packer.sv | 144 ++++++++++++++
 tb/tb_cpu_oci_trace_packer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_oci_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_oci_trace_pkg
// Brief  : Shared definitions for the OCI trace packer: default build
//          constants and the capture state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_oci_trace_pkg;

  localparam int DEF_FRAME_W    = 2;
  localparam int DEF_SLOTS      = 15;
  localparam int DEF_CNT_W      = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  // Capture lifecycle: pack frames, flush the partial word, wait for the
  // FIFO to drain, then report completion until reset.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ENDED = 2'd3
  } trace_state_e;

endpackage
`default_nettype wire

// File: rtl/cpu_oci_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module : cpu_oci_trace_fifo
// Brief  : Packed-word FIFO with a registered head output. A push into a
//          full FIFO is accepted only when a pop happens in the same cycle.
// Ports  : clk, reset        - clock, synchronous active-high reset
//          push_i/push_data_i - write request and word
//          pop_i             - consume head (ignored when empty)
//          full_o            - DEPTH words stored
//          valid_o, head_o   - head word present / head word (0 when empty)
// Rev    : 1.0  initial release
// ============================================================================
module cpu_oci_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (cnt_q != '0);
    do_push  = push_i && ((cnt_q != FULL_CNT) || do_pop);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head_d   = '0;
    // The slot being written becomes the head only when the FIFO is (or is
    // about to become) empty; memory is not yet updated, so bypass it.
    if (cnt_d != '0) begin
      head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign full_o  = (cnt_q == FULL_CNT);
  assign valid_o = (cnt_q != '0);
  assign head_o  = head_q;

endmodule
`default_nettype wire

// File: rtl/cpu_oci_trace_packer.sv
`default_nettype none
// ============================================================================
// Module : cpu_oci_trace_packer
// Brief  : Packs FRAME_W-bit trace frames into SLOTS-frame words (slot 0 in
//          the LSBs) and queues them in a small FIFO. test_ending flushes the
//          partial word, waits for the FIFO to drain, then raises
//          test_has_ended until reset.
// Ports  : clk, reset                - clock, synchronous active-high reset
//          frame_valid, frame_data   - incoming trace frame
//          test_ending               - one-cycle flush/finish request
//          dct_buffer, dct_count     - live partial word and its frame count
//          out_valid/out_ready       - FIFO head handshake
//          out_buffer, out_count     - FIFO head word and its frame count
//          overflow                  - sticky, a packed word was dropped
//          test_has_ended            - capture finished and FIFO drained
// Rev    : 1.0  initial release
// ============================================================================
module cpu_oci_trace_packer
  import cpu_oci_trace_pkg::*;
#(
  parameter int FRAME_W    = DEF_FRAME_W,
  parameter int SLOTS      = DEF_SLOTS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_valid,
  input  logic [FRAME_W-1:0]       frame_data,
  input  logic                     test_ending,
  output logic [FRAME_W*SLOTS-1:0] dct_buffer,
  output logic [CNT_W-1:0]         dct_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FRAME_W*SLOTS-1:0] out_buffer,
  output logic [CNT_W-1:0]         out_count,
  output logic                     overflow,
  output logic                     test_has_ended
);

  localparam int               WORD_W    = FRAME_W * SLOTS;
  localparam int               ENT_W     = WORD_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(SLOTS);

  trace_state_e      state_q;
  logic [WORD_W-1:0] buf_q, buf_d, buf_acc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              overflow_q, ended_q;
  logic              accept, complete, push, pop;
  logic [ENT_W-1:0]  push_ent, head_ent;
  logic              fifo_full, fifo_valid;

  always_comb begin
    buf_acc = buf_q;
    for (int s = 0; s < SLOTS; s++) begin
      if (cnt_q == CNT_W'(s)) begin
        buf_acc[s*FRAME_W +: FRAME_W] = frame_data;
      end
    end
    accept   = (state_q == ST_RUN) && frame_valid;
    complete = accept && (cnt_q == LAST_SLOT);
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    push_ent = '0;
    case (state_q)
      ST_RUN: begin
        if (complete) begin
          push     = 1'b1;
          push_ent = {FULL_CNT, buf_acc};
          buf_d    = '0;
          cnt_d    = '0;
        end else if (accept) begin
          buf_d = buf_acc;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        // Unused slots are already zero since the buffer clears on every push.
        if (cnt_q != '0) begin
          push     = 1'b1;
          push_ent = {cnt_q, buf_q};
        end
        buf_d = '0;
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  assign pop = fifo_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      buf_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      ended_q    <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      if (push && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        ST_RUN:   if (test_ending) state_q <= ST_FLUSH;
        ST_FLUSH: state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (!fifo_valid) begin
            state_q <= ST_ENDED;
            ended_q <= 1'b1;
          end
        end
        default:  state_q <= ST_ENDED;
      endcase
    end
  end

  cpu_oci_trace_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_ent),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .valid_o     (fifo_valid),
    .head_o      (head_ent)
  );

  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign out_valid      = fifo_valid;
  assign out_buffer     = head_ent[WORD_W-1:0];
  assign out_count      = head_ent[ENT_W-1 -: CNT_W];
  assign overflow       = overflow_q;
  assign test_has_ended = ended_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_oci_trace_packer.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_oci_trace_packer
// Brief  : Self-checking bench: directed scenarios plus random traffic,
//          compared every cycle against a transaction-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cpu_oci_trace_packer;

  localparam int SLOTS = 15;
  localparam int DEPTH = 4;
  localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2, M_ENDED = 3;

  logic        clk = 1'b0;
  logic        reset, frame_valid, test_ending, out_ready;
  logic [1:0]  frame_data;
  logic [29:0] dct_buffer, out_buffer;
  logic [3:0]  dct_count, out_count;
  logic        out_valid, overflow, test_has_ended;

  logic        rst2, fv2, te2, rdy2;
  logic [3:0]  fd2;
  logic [31:0] dct_buffer2, out_buffer2;
  logic [3:0]  dct_count2, out_count2;
  logic        out_valid2, overflow2, ended2;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct { logic [29:0] w; int c; } ent_t;
  logic [1:0] frames[$];
  ent_t       q[$];
  bit         m_ovf;
  int         mode;

  always #5 clk = ~clk;

  cpu_oci_trace_packer dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(frame_data),
    .test_ending(test_ending), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_buffer(out_buffer),
    .out_count(out_count), .overflow(overflow), .test_has_ended(test_has_ended)
  );

  cpu_oci_trace_packer #(.FRAME_W(4), .SLOTS(8), .CNT_W(4), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(rst2), .frame_valid(fv2), .frame_data(fd2),
    .test_ending(te2), .dct_buffer(dct_buffer2), .dct_count(dct_count2),
    .out_valid(out_valid2), .out_ready(rdy2), .out_buffer(out_buffer2),
    .out_count(out_count2), .overflow(overflow2), .test_has_ended(ended2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word value = sum of frame[i] * 4**i.
  function automatic logic [29:0] pack(input logic [1:0] fr[$]);
    logic [29:0] w = '0;
    for (int i = 0; i < fr.size(); i++) w = w | (30'(fr[i]) << (2 * i));
    return w;
  endfunction

  task automatic model_edge();
    bit   pop, full, push;
    ent_t e;
    if (reset) begin
      frames.delete(); q.delete(); m_ovf = 0; mode = M_RUN;
      return;
    end
    pop  = (q.size() > 0) && out_ready;
    full = (q.size() == DEPTH);
    push = 0;
    e.w  = '0;
    e.c  = 0;
    case (mode)
      M_RUN: begin
        if (frame_valid) begin
          frames.push_back(frame_data);
          if (frames.size() == SLOTS) begin
            push = 1; e.w = pack(frames); e.c = SLOTS; frames.delete();
          end
        end
        if (test_ending) mode = M_FLUSH;
      end
      M_FLUSH: begin
        if (frames.size() > 0) begin
          push = 1; e.w = pack(frames); e.c = frames.size(); frames.delete();
        end
        mode = M_DRAIN;
      end
      M_DRAIN: if (q.size() == 0) mode = M_ENDED;
      default: ;
    endcase
    if (pop) void'(q.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1;
      else q.push_back(e);
    end
  endtask

  task automatic compare_all();
    check("dct_count", 64'(dct_count), 64'(frames.size()));
    check("dct_buffer", 64'(dct_buffer), 64'(pack(frames)));
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_buffer", 64'(out_buffer), 64'(q[0].w));
      check("out_count", 64'(out_count), 64'(q[0].c));
    end
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("test_has_ended", 64'(test_has_ended), 64'(mode == M_ENDED));
  endtask

  task automatic step(input logic r, input logic fv, input logic [1:0] fd,
                      input logic te, input logic rdy);
    reset = r; frame_valid = fv; frame_data = fd; test_ending = te; out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1; frame_valid = 0; frame_data = 0; test_ending = 0; out_ready = 0;
    rst2 = 1; fv2 = 0; fd2 = 0; te2 = 0; rdy2 = 0;
    mode = M_RUN; m_ovf = 0;

    // Reset state
    step(1, 1, 2'b11, 1, 1);
    step(1, 0, 0, 0, 0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_buffer", 64'(out_buffer), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_ended", 64'(test_has_ended), 64'd0);

    // 15 frames of 01 -> 30'h15555555, valid the cycle after frame 15
    repeat (14) step(0, 1, 2'b01, 0, 0);
    check("full_word_not_early", 64'(out_valid), 64'd0);
    step(0, 1, 2'b01, 0, 0);
    check("full_word_valid", 64'(out_valid), 64'd1);
    check("full_word_value", 64'(out_buffer), 64'h15555555);
    check("full_word_count", 64'(out_count), 64'd15);
    step(0, 0, 0, 0, 0);
    check("hold_value", 64'(out_buffer), 64'h15555555);
    step(0, 0, 0, 0, 1);

    // Random traffic with random back-pressure
    repeat (400) step(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0,
                      1'($urandom_range(0, 1)));

    // Overflow: 5 words with no consumer, 4 kept intact
    step(1, 0, 0, 0, 0);
    check("ovf_clear", 64'(overflow), 64'd0);
    repeat (75) step(0, 1, 2'($urandom_range(0, 3)), 0, 0);
    check("ovf_set", 64'(overflow), 64'd1);
    repeat (6) step(0, 0, 0, 0, 1);
    check("ovf_drained", 64'(out_valid), 64'd0);

    // Reset mid-operation with 7 partial frames and 2 queued words
    step(1, 0, 0, 0, 0);
    repeat (37) step(0, 1, 2'($urandom_range(0, 3)), 0, 0);
    check("pre_rst_count", 64'(dct_count), 64'd7);
    step(1, 1, 2'b11, 1, 1);
    check("mid_rst_dct_count", 64'(dct_count), 64'd0);
    check("mid_rst_dct_buffer", 64'(dct_buffer), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_buffer", 64'(out_buffer), 64'd0);
    check("mid_rst_out_count", 64'(out_count), 64'd0);
    step(0, 1, 2'b10, 0, 0);
    check("post_rst_slot0", 64'(dct_buffer), 64'h2);

    // Partial word flush: frames 2,1,2,3,1 -> 30'h1E6, count 5
    step(1, 0, 0, 0, 0);
    step(0, 1, 2'd2, 0, 0);
    step(0, 1, 2'd1, 0, 0);
    step(0, 1, 2'd2, 0, 0);
    step(0, 1, 2'd3, 0, 0);
    step(0, 1, 2'd1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 2'd3, 1, 0);
    check("flush_word", 64'(out_buffer), 64'h1E6);
    check("flush_count", 64'(out_count), 64'd5);
    check("flush_not_ended", 64'(test_has_ended), 64'd0);
    for (int i = 0; i < 20 && !test_has_ended; i++) step(0, 1, 2'($urandom_range(0, 3)), 1, 1);
    check("flush_ended", 64'(test_has_ended), 64'd1);
    repeat (4) step(0, 1, 2'b11, 1, 1);
    check("ended_ignores_frames", 64'(dct_count), 64'd0);

    // test_ending together with the 15th frame: one full word, no empty word
    step(1, 0, 0, 0, 0);
    repeat (14) step(0, 1, 2'($urandom_range(0, 3)), 0, 0);
    step(0, 1, 2'b10, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("te15_count", 64'(out_count), 64'd15);
    for (int i = 0; i < 20 && !test_has_ended; i++) step(0, 0, 0, 0, 1);
    check("te15_ended", 64'(test_has_ended), 64'd1);
    check("te15_no_extra", 64'(out_valid), 64'd0);

    // Non-default build: FRAME_W=4, SLOTS=8
    @(posedge clk); #1;
    rst2 = 0; fv2 = 1; fd2 = 4'hA;
    repeat (7) @(posedge clk);
    #1;
    check("nd_count7", 64'(dct_count2), 64'd7);
    check("nd_not_valid", 64'(out_valid2), 64'd0);
    @(posedge clk); #1;
    fv2 = 0;
    check("nd_valid", 64'(out_valid2), 64'd1);
    check("nd_word", 64'(out_buffer2), 64'hAAAAAAAA);
    check("nd_out_count", 64'(out_count2), 64'd8);
    check("nd_dct_clear", 64'(dct_count2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
